pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the RV32I core.
- Holds the PC and issues fetch requests to instruction memory over a req/gnt/rvalid handshake.
- Presents each fetched word to decode over a valid/ready handshake.
- Computes the next PC from the pcsource select, the extended immediate produced by the immediate extender, and rs1, all sampled when decode accepts the current instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, redirect target for a misaligned fetch (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  reset, synchronous, active-low.
- pcsource  in  2  next-PC select: 00 pc+4, 01 branch pc+imm, 10 jalr (rs1+imm)&~1, 11 jal pc+imm.
- immediate  in  32  extended immediate (branch/jal offset or I-type imm) from the immediate extender.
- rs1_data  in  32  register-file rs1, used for jalr.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- inst  out  32  fetched instruction (registered).
- pc  out  32  address of inst.
- pc_plus4  out  32  pc+4 (link value for jal/jalr).
- inst_valid  out  1  inst/pc valid to decode.
- inst_ready  in  1  decode consumes inst this cycle.
- trap_misalign  out  1  one-cycle pulse on misaligned redirect.
- bad_addr  out  32  offending target, held until the next trap.

Behaviour:
- Reset (clrn=0 at a rising edge), regardless of state:
  - pc=RESET_PC, inst=32'h0000_0013 (nop), inst_valid=0, imem_req=0.
  - trap_misalign=0, bad_addr=0, state=S_REQ.
  - Any pending memory response is abandoned; imem must be reset concurrently.
- FSM states S_REQ, S_WAIT, S_VALID:
  - S_REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> S_WAIT; else stay, with req and addr held stable.
  - S_WAIT: imem_req=0. imem_rvalid=1 -> inst<=imem_rdata, -> S_VALID.
  - S_VALID: inst_valid=1, pc and inst stable. inst_ready=1 -> pc<=next_pc, inst_valid<=0, -> S_REQ. inst_ready=0 -> hold indefinitely (stall).
- imem_rvalid is ignored outside S_WAIT, and rvalid in the same cycle as gnt is ignored.
- Best-case throughput is one instruction per 3 cycles: gnt in cycle 0, rvalid in cycle 1, consumed in cycle 2.
- next_pc is combinational from pcsource, immediate and rs1_data, sampled only on the S_VALID & inst_ready edge.
- Arithmetic is 32-bit modulo 2^32; no overflow detection. pc=32'hFFFF_FFFC with pcsource 00 gives next_pc=0.
- pc_plus4 = pc+4, combinational from the pc register.
- jalr always clears bit 0; branch/jal bit 0 is already 0 from the extender.
- inst_ready while inst_valid=0 has no effect.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: if next_pc[1]=1 at the consume edge:
  - pc<=TRAP_VEC, bad_addr<=next_pc.
  - trap_misalign=1 for exactly the following cycle, coincident with entry to S_REQ.
  - Fetch proceeds from TRAP_VEC.
- Undefined:
  - pc<={next_pc[31:2],2'b00}.
  - trap_misalign tied 0, bad_addr tied 0.

Test Plan:
- Reset then sequential fetch: clrn low 2 cycles, gnt immediate, rvalid 1 cycle later, ready always 1 -> imem_addr 0x0,0x4,0x8; inst_valid every 3rd cycle; inst matches rdata.
- Branch: pc=0x10, pcsource=01, immediate=0xFFFF_FFF8 -> next imem_addr=0x08. jal: pc=0x08, pcsource=11, imm=0x100 -> 0x108.
- jalr: pcsource=10, rs1=0x2001, imm=0x0F -> next pc=0x2010. rs1=0x1000, imm=0x3 -> 0x1002, which traps (macro on: pc=0x100, bad_addr=0x1002, one-cycle pulse) or fetches 0x1000 (macro off).
- Stalls: gnt withheld 3 cycles -> imem_addr and req stable. inst_ready low 5 cycles in S_VALID -> pc and inst unchanged, no new request.
- Wrap and stale data: pc=0xFFFF_FFFC, pcsource=00 -> next fetch at 0x0. rvalid pulsed in S_REQ -> inst unchanged.
- Reset mid-operation: clrn low while in S_WAIT -> pc=RESET_PC, inst_valid=0; subsequent fetch from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage of the RV32I core.
// Issues fetches over req/gnt/rvalid and hands each word to decode over
// valid/ready. Optional build macro PC_MISALIGN_TRAP_EN redirects a target
// with bit 1 set to TRAP_VEC and reports it on trap_misalign / bad_addr.
//
// state   | meaning
// S_REQ   | request outstanding at imem_addr = pc, waiting for gnt
// S_WAIT  | granted, waiting for rvalid
// S_VALID | inst/pc presented to decode, waiting for inst_ready
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] immediate,
    input  logic [31:0] rs1_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        trap_misalign,
    output logic [31:0] bad_addr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic        consume;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign consume   = (state == S_VALID) && inst_ready;

    // Next-PC select; only looked at on the consume edge.
    always_comb begin
        next_pc = pc + 32'd4;
        case (pcsource)
            2'b00: next_pc = pc + 32'd4;
            2'b01: next_pc = pc + immediate;
            2'b10: next_pc = (rs1_data + immediate) & ~32'h1;
            2'b11: next_pc = pc + immediate;
            default: next_pc = pc + 32'd4;
        endcase
    end

    // Fetch FSM: the request goes high one cycle after reset, then stays high
    // from the consume edge so a granted fetch completes in three cycles.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state      <= S_REQ;
            imem_req   <= 1'b0;
            inst       <= NOP;
            inst_valid <= 1'b0;
            pc         <= RESET_PC;
        end else begin
            case (state)
                S_REQ: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= S_REQ;
`ifdef PC_MISALIGN_TRAP_EN
                        pc <= next_pc[1] ? TRAP_VEC : next_pc;
`else
                        pc <= next_pc & ~32'h3;
`endif
                    end
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // One-cycle trap pulse and sticky offending address on a misaligned redirect.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            trap_misalign <= 1'b0;
            bad_addr      <= 32'h0;
        end else begin
            trap_misalign <= consume && next_pc[1];
            if (consume && next_pc[1]) begin
                bad_addr <= next_pc;
            end
        end
    end
`else
    // Trap outputs are constant zero; TRAP_VEC is masked in so both builds
    // share the same parameter list without an unused parameter.
    assign trap_misalign = 1'b0;
    assign bad_addr      = TRAP_VEC & 32'h0;
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit with a reference PC model built from
// the next-PC rules in plain arithmetic; memory contents are a hash of address.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] immediate = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        trap_misalign;
    logic [31:0] bad_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_pc;
    logic        exp_trap;
    logic [31:0] exp_bad;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk(clk), .clrn(clrn), .pcsource(pcsource), .immediate(immediate),
        .rs1_data(rs1_data), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .trap_misalign(trap_misalign), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Reference: where the PC goes after decode accepts an instruction.
    function automatic void model_step(input logic [1:0] src, input logic [31:0] imm,
                                       input logic [31:0] rs1);
        logic [31:0] tgt;
        case (src)
            2'd0: tgt = exp_pc + 4;
            2'd2: tgt = (rs1 + imm) & 32'hFFFF_FFFE;
            default: tgt = exp_pc + imm;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        if (tgt[1]) begin
            exp_pc = TRAP_VEC; exp_trap = 1'b1; exp_bad = tgt;
        end else begin
            exp_pc = tgt; exp_trap = 1'b0;
        end
`else
        exp_pc = {tgt[31:2], 2'b00}; exp_trap = 1'b0; exp_bad = 32'h0;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full fetch/present/consume round trip driven as the memory and decode.
    task automatic do_fetch(input int gnt_dly, input int rv_dly, input int rdy_dly,
                            input logic [1:0] src, input logic [31:0] imm, input logic [31:0] rs1,
                            output logic [31:0] o_addr, output logic [31:0] o_inst,
                            output logic [31:0] o_pc, output logic [31:0] o_pc4,
                            output logic o_trap, output logic [31:0] o_bad,
                            output bit o_req_ok, output bit o_hold_ok,
                            output bit o_timeout, output int o_cycles);
        logic [31:0] inst0;
        int w;
        o_req_ok = 1; o_hold_ok = 1; o_timeout = 0; o_cycles = 0;
        o_addr = 'x; o_inst = 'x; o_pc = 'x; o_pc4 = 'x; o_trap = 1'bx; o_bad = 'x;
        w = 0;
        while (!imem_req && w < 4) begin tick(); w++; end
        if (!imem_req) begin o_timeout = 1; return; end
        o_addr = imem_addr;
        inst0 = inst;
        for (int i = 0; i < gnt_dly; i++) begin
            imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = ~mem_word(o_addr);
            tick();
            if (!imem_req || imem_addr !== o_addr || inst !== inst0) o_req_ok = 0;
        end
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = ~mem_word(o_addr) ^ 32'h5A;
        tick(); o_cycles++;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        for (int i = 0; i < rv_dly; i++) begin
            tick(); o_cycles++;
            if (imem_req || inst_valid) o_req_ok = 0;
        end
        if (inst_valid) o_req_ok = 0;
        imem_rvalid = 1'b1; imem_rdata = mem_word(o_addr);
        tick(); o_cycles++;
        imem_rvalid = 1'b0;
        if (!inst_valid) begin o_timeout = 1; return; end
        o_inst = inst; o_pc = pc; o_pc4 = pc_plus4;
        for (int i = 0; i < rdy_dly; i++) begin
            inst_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom;
            tick(); o_cycles++;
            if (inst !== o_inst || pc !== o_pc || !inst_valid || imem_req) o_hold_ok = 0;
        end
        imem_rvalid = 1'b0;
        pcsource = src; immediate = imm; rs1_data = rs1; inst_ready = 1'b1;
        tick(); o_cycles++;
        inst_ready = 1'b0;
        o_trap = trap_misalign; o_bad = bad_addr;
    endtask

    logic [31:0] f_addr, f_inst, f_pc, f_pc4, f_bad;
    logic        f_trap;
    bit          f_req_ok, f_hold_ok, f_to;
    int          f_cyc;

    task automatic test_reset;
        clrn = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        tick(); tick();
        clrn = 1'b1;
        exp_pc = RESET_PC; exp_trap = 1'b0; exp_bad = 32'h0;
        n_cmp++; if (pc !== RESET_PC) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC); end
        n_cmp++; if (inst !== NOP) begin n_err++; $display("FAIL reset_inst got %h want %h", inst, NOP); end
        n_cmp++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL reset_valid_req got %b%b want 00", inst_valid, imem_req); end
        n_cmp++; if (trap_misalign !== 1'b0 || bad_addr !== 32'h0) begin n_err++; $display("FAIL reset_trap got %b/%h want 0/0", trap_misalign, bad_addr); end
    endtask

    task automatic test_sequential;
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, 0, 0, 2'b00, 32'h0, 32'h0, f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
            n_cmp++; if (f_to) begin n_err++; $display("FAIL seq_timeout k=%0d got 1 want 0", k); end
            n_cmp++; if (f_addr !== 32'(4 * k)) begin n_err++; $display("FAIL seq_addr got %h want %h", f_addr, 32'(4 * k)); end
            n_cmp++; if (f_inst !== mem_word(32'(4 * k))) begin n_err++; $display("FAIL seq_inst got %h want %h", f_inst, mem_word(32'(4 * k))); end
            n_cmp++; if (f_pc4 !== 32'(4 * k + 4)) begin n_err++; $display("FAIL seq_pc_plus4 got %h want %h", f_pc4, 32'(4 * k + 4)); end
            n_cmp++; if (f_cyc != 3 || !f_req_ok) begin n_err++; $display("FAIL seq_cycles got %0d ok=%0d want 3 ok=1", f_cyc, f_req_ok); end
            model_step(2'b00, 32'h0, 32'h0);
        end
    endtask

    task automatic test_branch_jal;
        logic [1:0]  src [3] = '{2'b11, 2'b01, 2'b11};
        logic [31:0] imm [3] = '{32'h4, 32'hFFFF_FFF8, 32'h100};
        logic [31:0] want[3] = '{32'h10, 32'h08, 32'h108};
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, 1, 0, src[k], imm[k], 32'h0, f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
            model_step(src[k], imm[k], 32'h0);
            n_cmp++; if (f_to || f_addr !== f_pc) begin n_err++; $display("FAIL br_fetch to=%0d addr %h pc %h", f_to, f_addr, f_pc); end
            n_cmp++; if (imem_addr !== want[k] || exp_pc !== want[k]) begin n_err++; $display("FAIL br_target got %h want %h", imem_addr, want[k]); end
        end
    endtask

    task automatic test_jalr;
        do_fetch(1, 0, 0, 2'b10, 32'h0F, 32'h2001, f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
        model_step(2'b10, 32'h0F, 32'h2001);
        n_cmp++; if (f_to || pc !== 32'h2010) begin n_err++; $display("FAIL jalr_target got %h want 00002010", pc); end
        do_fetch(0, 0, 0, 2'b10, 32'h3, 32'h1000, f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
        model_step(2'b10, 32'h3, 32'h1000);
        n_cmp++; if (f_inst !== mem_word(32'h2010)) begin n_err++; $display("FAIL jalr_inst got %h want %h", f_inst, mem_word(32'h2010)); end
`ifdef PC_MISALIGN_TRAP_EN
        n_cmp++; if (pc !== 32'h100 || f_bad !== 32'h1002 || f_trap !== 1'b1) begin n_err++; $display("FAIL jalr_trap pc %h bad %h trap %b want 100/1002/1", pc, f_bad, f_trap); end
`else
        n_cmp++; if (pc !== 32'h1000 || f_bad !== 32'h0 || f_trap !== 1'b0) begin n_err++; $display("FAIL jalr_align pc %h bad %h trap %b want 1000/0/0", pc, f_bad, f_trap); end
`endif
        imem_gnt = 1'b0;
        tick();
        n_cmp++; if (trap_misalign !== 1'b0 || imem_addr !== exp_pc || imem_req !== 1'b1) begin n_err++; $display("FAIL trap_pulse_end trap %b addr %h want 0/%h", trap_misalign, imem_addr, exp_pc); end
        n_cmp++; if (bad_addr !== exp_bad) begin n_err++; $display("FAIL bad_addr_hold got %h want %h", bad_addr, exp_bad); end
    endtask

    task automatic test_stalls;
        do_fetch(3, 2, 5, 2'b00, 32'h0, 32'h0, f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
        n_cmp++; if (!f_req_ok) begin n_err++; $display("FAIL stall_gnt_req_stable got 0 want 1"); end
        n_cmp++; if (!f_hold_ok) begin n_err++; $display("FAIL stall_ready_hold got 0 want 1"); end
        n_cmp++; if (f_inst !== mem_word(exp_pc) || f_pc !== exp_pc) begin n_err++; $display("FAIL stall_inst got %h/%h want %h/%h", f_inst, f_pc, mem_word(exp_pc), exp_pc); end
        model_step(2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_wrap;
        do_fetch(0, 0, 0, 2'b10, 32'h0, 32'hFFFF_FFFC, f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
        model_step(2'b10, 32'h0, 32'hFFFF_FFFC);
        do_fetch(2, 0, 0, 2'b00, 32'h0, 32'h0, f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
        n_cmp++; if (f_addr !== 32'hFFFF_FFFC || f_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h/%h want fffffffc/0", f_addr, f_pc4); end
        n_cmp++; if (!f_req_ok || f_inst !== mem_word(32'hFFFF_FFFC)) begin n_err++; $display("FAIL stale_rvalid inst %h want %h", f_inst, mem_word(32'hFFFF_FFFC)); end
        model_step(2'b00, 32'h0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next got %h want 0", imem_addr); end
    endtask

    task automatic test_reset_mid;
        int w = 0;
        while (!imem_req && w < 4) begin tick(); w++; end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        clrn = 1'b0; tick(); clrn = 1'b1;
        exp_pc = RESET_PC; exp_trap = 1'b0; exp_bad = 32'h0;
        n_cmp++; if (pc !== RESET_PC || inst_valid !== 1'b0 || inst !== NOP) begin n_err++; $display("FAIL midreset pc %h valid %b inst %h", pc, inst_valid, inst); end
        do_fetch(0, 0, 0, 2'b00, 32'h0, 32'h0, f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
        n_cmp++; if (f_to || f_addr !== RESET_PC || f_inst !== mem_word(RESET_PC)) begin n_err++; $display("FAIL midreset_fetch got %h/%h want %h", f_addr, f_inst, RESET_PC); end
        model_step(2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_random;
        logic [1:0]  s;
        logic [31:0] im, r1, want_pc, want_bad;
        logic        want_trap;
        for (int k = 0; k < 60; k++) begin
            s  = 2'($urandom_range(0, 3));
            im = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFE) : 32'($urandom_range(0, 64)) & 32'hFFFF_FFFE;
            r1 = $urandom;
            want_pc = exp_pc;
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), s, im, r1,
                     f_addr, f_inst, f_pc, f_pc4, f_trap, f_bad, f_req_ok, f_hold_ok, f_to, f_cyc);
            model_step(s, im, r1);
            want_trap = exp_trap; want_bad = exp_bad;
            n_cmp++; if (f_to) begin n_err++; $display("FAIL rnd_timeout k=%0d got 1 want 0", k); end
            n_cmp++; if (f_addr !== want_pc || f_pc !== want_pc) begin n_err++; $display("FAIL rnd_pc k=%0d got %h/%h want %h", k, f_addr, f_pc, want_pc); end
            n_cmp++; if (f_inst !== mem_word(want_pc) || f_pc4 !== want_pc + 4) begin n_err++; $display("FAIL rnd_inst k=%0d got %h/%h want %h", k, f_inst, f_pc4, mem_word(want_pc)); end
            n_cmp++; if (!f_req_ok || !f_hold_ok) begin n_err++; $display("FAIL rnd_handshake k=%0d req_ok %0d hold_ok %0d want 1 1", k, f_req_ok, f_hold_ok); end
            n_cmp++; if (f_trap !== want_trap || f_bad !== want_bad) begin n_err++; $display("FAIL rnd_trap k=%0d got %b/%h want %b/%h", k, f_trap, f_bad, want_trap, want_bad); end
            n_cmp++; if (imem_addr !== exp_pc) begin n_err++; $display("FAIL rnd_next k=%0d got %h want %h", k, imem_addr, exp_pc); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_jal();
        test_jalr();
        test_stalls();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
